// File: rtl/ifu_prefetch_if.sv
// Fetch-unit bus bundle: redirect input, instruction-memory request/grant/response
// channel and the valid/ready instruction channel toward decode.
interface ifu_prefetch_if;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    modport master (
        input  redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, out_ready,
        output imem_req, imem_addr, out_valid, out_instr, out_pc
    );

    modport slave (
        output redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, out_ready,
        input  imem_req, imem_addr, out_valid, out_instr, out_pc
    );
endinterface

// File: rtl/ifu_prefetch.sv
// Instruction fetch unit: one-outstanding-request fetcher feeding a DEPTH-entry
// {pc, instr} prefetch queue, flushed and restarted on redirect.
module ifu_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic            clk,
    input logic            rstn,
    ifu_prefetch_if.master bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int AW = CW - 1;
    localparam logic [31:0] RESET_PC_W = {RESET_PC[31:2], 2'b00};

    typedef enum logic [1:0] {IDLE, REQ, RSP, DROP} state_t;

    state_t          state;
    logic            req_q;
    logic            valid_q;
    logic [31:0]     fetch_pc;
    logic [31:0]     grant_pc;
    logic [31:0]     fifo_pc    [DEPTH];
    logic [31:0]     fifo_instr [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    logic            push;
    logic            pop;
    logic            redirect_to_req;
    logic [31:0]     redirect_pc_w;
    logic            unused_pc_bits;

    assign push          = (state == RSP) && bus.imem_rvalid && !bus.redirect;
    assign pop           = valid_q && bus.out_ready;
    assign redirect_pc_w = {bus.redirect_pc[31:2], 2'b00};
    assign unused_pc_bits = ^bus.redirect_pc[1:0];

    // A redirect only needs DROP when a granted response is still in flight after this edge.
    assign redirect_to_req = (state == IDLE)
                          || ((state == REQ) && !bus.imem_gnt)
                          || (((state == RSP) || (state == DROP)) && bus.imem_rvalid);

    // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        count_next = count;
        if (bus.redirect) begin
            count_next = '0;
        end else begin
            count_next = count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            valid_q <= 1'b0;
            // NOTE: the storage is reset because the head mux drives out_instr/out_pc directly.
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc[i]    <= '0;
                fifo_instr[i] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            count   <= count_next;
            valid_q <= (count_next != '0);
            if (bus.redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) begin
                    fifo_pc[wr_ptr]    <= grant_pc;
                    fifo_instr[wr_ptr] <= bus.imem_rdata;
                    wr_ptr             <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            req_q    <= 1'b0;
            fetch_pc <= RESET_PC_W;
            grant_pc <= '0;
        end else if (bus.redirect) begin
            fetch_pc <= redirect_pc_w;
            state    <= redirect_to_req ? REQ : DROP;
            req_q    <= redirect_to_req;
        end else begin
            case (state)
                IDLE: begin
                    if (count < CW'(DEPTH)) begin
                        state <= REQ;
                        req_q <= 1'b1;
                    end
                end
                REQ: begin
                    if (bus.imem_gnt) begin
                        grant_pc <= fetch_pc;
                        fetch_pc <= fetch_pc + 32'd4;
                        state    <= RSP;
                        req_q    <= 1'b0;
                    end
                end
                RSP: begin
                    if (bus.imem_rvalid) begin
                        if (count_next < CW'(DEPTH)) begin
                            state <= REQ;
                            req_q <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DROP: begin
                    if (bus.imem_rvalid) begin
                        state <= REQ;
                        req_q <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_req  = req_q;
    assign bus.imem_addr = fetch_pc;
    assign bus.out_valid = valid_q;
    assign bus.out_instr = fifo_instr[rd_ptr];
    assign bus.out_pc    = fifo_pc[rd_ptr];
endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch: variable-latency memory model, expected
// {pc, instr} scoreboard filled when stimulus is driven and drained on handshakes.
module tb_ifu_prefetch;
    logic clk = 1'b0;
    logic rstn;

    ifu_prefetch_if bus ();

    ifu_prefetch #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    int          errors = 0;
    int          checks = 0;
    entry_t      sb[$];
    entry_t      e;
    logic [31:0] grant_log[$];
    int          grant_cyc[$];
    int          cycle = 0;
    int          lat   = 1;
    bit          pend  = 1'b0;
    int          cnt   = 0;
    logic [31:0] paddr = '0;
    logic        s_gnt = 1'b0;
    logic [31:0] s_addr = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [31:0] glog(input int i);
        return (i < grant_log.size()) ? grant_log[i] : 32'hDEAD_BEEF;
    endfunction

    // Memory model: sample request/grant mid-cycle, answer lat cycles after the grant cycle.
    always @(negedge clk) begin
        s_gnt  = bus.imem_req & bus.imem_gnt;
        s_addr = bus.imem_addr;
    end

    always @(posedge clk) begin
        cycle++;
        if (s_gnt) begin
            grant_log.push_back(s_addr);
            grant_cyc.push_back(cycle);
        end
        #1;
        bus.imem_rvalid = 1'b0;
        if (pend) cnt--;
        if (s_gnt) begin
            pend  = 1'b1;
            cnt   = lat - 1;
            paddr = s_addr;
        end
        if (pend && cnt == 0) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem_word(paddr);
            pend            = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_seq(input logic [31:0] start, input int n);
        logic [31:0] pc;
        for (int i = 0; i < n; i++) begin
            pc = start + 32'(4 * i);
            sb.push_back({pc, mem_word(pc)});
        end
    endtask

    // Accept exactly n words, comparing each head against the scoreboard before its handshake.
    task automatic consume(input string tag, input int n, input int budget);
        int     got = 0;
        entry_t x;
        for (int c = 0; c < budget && got < n; c++) begin
            if (bus.out_valid === 1'b1 && sb.size() > 0) begin
                x = sb.pop_front();
                check({tag, "_pc"}, bus.out_pc, x.pc);
                check({tag, "_instr"}, bus.out_instr, x.instr);
                got++;
                bus.out_ready = 1'b1;
            end else begin
                bus.out_ready = 1'b0;
            end
            step();
        end
        bus.out_ready = 1'b0;
        check({tag, "_count"}, 32'(got), 32'(n));
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        bus.redirect    = 1'b1;
        bus.redirect_pc = pc;
        step();
        bus.redirect    = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rstn            = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.imem_gnt    = 1'b1;
        bus.out_ready   = 1'b0;
        repeat (3) step();
        check("rst_req",   bus.imem_req,  32'd0);
        check("rst_addr",  bus.imem_addr, 32'h0);
        check("rst_valid", bus.out_valid, 32'd0);
        check("rst_instr", bus.out_instr, 32'h0);
        check("rst_pc",    bus.out_pc,    32'h0);

        // Zero-wait memory after reset release.
        expect_seq(32'h0, 8);
        rstn = 1'b1;
        step();
        check("t1_first_req",  bus.imem_req,  32'd1);
        check("t1_first_addr", bus.imem_addr, 32'h0);
        step();
        check("t1_no_bypass",  bus.out_valid, 32'd0);
        step();
        check("t1_first_valid", bus.out_valid, 32'd1);
        consume("t1", 8, 60);
        for (int i = 0; i < 4; i++) begin
            check("t1_grant_addr", glog(i), 32'(4 * i));
        end
        for (int i = 0; i < 3; i++) begin
            check("t1_grant_gap", 32'(grant_cyc[i + 1] - grant_cyc[i]), 32'd2);
        end

        // Backpressure fills the queue, then drains in order.
        do_redirect(32'h0);
        grant_log.delete();
        repeat (30) step();
        check("t2_grants", 32'(grant_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("t2_grant_addr", glog(i), 32'(4 * i));
        end
        check("t2_req_idle", bus.imem_req,  32'd0);
        check("t2_valid",    bus.out_valid, 32'd1);
        check("t2_head_pc",  bus.out_pc,    32'h0);
        check("t2_head_ins", bus.out_instr, mem_word(32'h0));
        repeat (3) step();
        check("t2_head_held", bus.out_pc, 32'h0);
        expect_seq(32'h0, 8);
        consume("t2", 8, 80);
        check("t2_resume", glog(4), 32'h10);

        // Redirect while a 3-cycle response is outstanding.
        lat = 3;
        do_redirect(32'h200);
        grant_log.delete();
        for (int c = 0; c < 20 && grant_log.size() == 0; c++) step();
        check("t3_grant_200", glog(0), 32'h200);
        do_redirect(32'h0000_0102);
        check("t3_drop_req", bus.imem_req, 32'd0);
        grant_log.delete();
        expect_seq(32'h100, 3);
        consume("t3", 3, 80);
        check("t3_grant_100", glog(0), 32'h100);

        // Redirect coinciding with rvalid and an output handshake.
        lat = 1;
        do_redirect(32'h300);
        for (int c = 0; c < 30 && !(bus.out_valid === 1'b1 && bus.imem_rvalid === 1'b1); c++) step();
        check("t4_setup", 32'(bus.out_valid & bus.imem_rvalid), 32'd1);
        expect_seq(32'h300, 1);
        e = sb.pop_front();
        check("t4_pop_pc",  bus.out_pc,    e.pc);
        check("t4_pop_ins", bus.out_instr, e.instr);
        bus.out_ready = 1'b1;
        do_redirect(32'h400);
        bus.out_ready = 1'b0;
        check("t4_empty", bus.out_valid, 32'd0);
        check("t4_req",   bus.imem_req,  32'd1);
        check("t4_addr",  bus.imem_addr, 32'h400);
        expect_seq(32'h400, 2);
        consume("t4", 2, 40);

        // Address wrap at the top of the address space.
        do_redirect(32'hFFFF_FFF8);
        expect_seq(32'hFFFF_FFF8, 4);
        consume("t5", 4, 60);

        // Reset while granted and awaiting the response.
        lat = 3;
        do_redirect(32'h500);
        grant_log.delete();
        for (int c = 0; c < 60 && grant_log.size() < 2; c++) step();
        check("t6_two_grants", 32'(grant_log.size() >= 2), 32'd1);
        check("t6_pre_valid",  bus.out_valid, 32'd1);
        #1;
        bus.imem_gnt = 1'b0;
        rstn         = 1'b0;
        #1;
        check("t6_rst_req",   bus.imem_req,  32'd0);
        check("t6_rst_addr",  bus.imem_addr, 32'h0);
        check("t6_rst_valid", bus.out_valid, 32'd0);
        check("t6_rst_pc",    bus.out_pc,    32'h0);
        check("t6_rst_instr", bus.out_instr, 32'h0);
        step();
        rstn = 1'b1;
        step();
        check("t6_restart_req",  bus.imem_req,  32'd1);
        check("t6_restart_addr", bus.imem_addr, 32'h0);
        step();
        lat = 1;
        grant_log.delete();
        bus.imem_gnt = 1'b1;
        expect_seq(32'h0, 3);
        consume("t6", 3, 60);
        check("t6_grant_0", glog(0), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
